id_rn_queue: RTL and testbench

Parametrised decode-to-rename decoupling queue, successor to the single-entry ID/RN pipeline register. Holds up to DEPTH decoded instruction bundles (PC plus packed control payload) between the decode and rename stages. Uses a valid/ready handshake in place of a bare stall input. Supports a whole-queue flush on redirect and a global enable.

---
 rtl/id_rn_queue.sv | 89 ++++++++
 tb/tb_id_rn_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_rn_queue.sv
// Decode-to-rename decoupling queue: DEPTH-entry circular buffer with valid/ready handshake.
// Optional stall-cycle performance counter is enabled by defining ID_RN_PERF_CNT_EN.
module id_rn_queue #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [PC_W-1:0]   i_id_pc,
  input  logic [DATA_W-1:0] i_id_data,
  output logic              o_id_ready,
  output logic              o_rn_valid,
  output logic [PC_W-1:0]   o_rn_pc,
  output logic [DATA_W-1:0] o_rn_data,
  input  logic              i_rn_ready,
`ifdef ID_RN_PERF_CNT_EN
  output logic [31:0]       o_rn_stall_cycles,
`endif
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned ENT_W = PC_W + DATA_W;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [ENT_W-1:0] r_mem [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_occ;
  logic [ENT_W-1:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Same slot but opposite wrap bit means the writer has lapped the reader.
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_occ   = r_wr_ptr - r_rd_ptr;

  assign o_id_ready = i_en & ~w_full & ~i_flush;
  assign o_rn_valid = ~w_empty;
  assign w_push     = i_id_valid & o_id_ready;
  assign w_pop      = o_rn_valid & i_rn_ready & i_en & ~i_flush;

  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign o_rn_pc   = w_head[ENT_W-1:DATA_W];
  assign o_rn_data = w_head[DATA_W-1:0];
  assign o_count   = CNT_W'(w_occ);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_en && i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage is never cleared; only the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_wr_ptr[AW-1:0]] <= {i_id_pc, i_id_data};
  end

`ifdef ID_RN_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (i_id_valid && i_en && w_full && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_rn_stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_rn_queue.sv
// Self-checking bench for id_rn_queue: queue-based reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_id_rn_queue;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst, en, flush, id_valid, rn_ready;
  logic [PC_W-1:0]   id_pc;
  logic [DATA_W-1:0] id_data;
  logic              id_ready, rn_valid;
  logic [PC_W-1:0]   rn_pc;
  logic [DATA_W-1:0] rn_data;
  logic [CNT_W-1:0]  count;
`ifdef ID_RN_PERF_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Reference model: a plain queue of {pc, data}.
  logic [PC_W+DATA_W-1:0] mq[$];
  longint unsigned        m_stall = 0;

  id_rn_queue #(
    .DATA_W(DATA_W),
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_en             (en),
    .i_flush          (flush),
    .i_id_valid       (id_valid),
    .i_id_pc          (id_pc),
    .i_id_data        (id_data),
    .o_id_ready       (id_ready),
    .o_rn_valid       (rn_valid),
    .o_rn_pc          (rn_pc),
    .o_rn_data        (rn_data),
    .i_rn_ready       (rn_ready),
`ifdef ID_RN_PERF_CNT_EN
    .o_rn_stall_cycles(stall_cycles),
`endif
    .o_count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input logic [PC_W-1:0] pc);
    return {~pc, pc ^ 32'h5A5A_0000};
  endfunction

  // Compare on the falling edge, then advance the model with the inputs that the next
  // rising edge will sample.
  always @(negedge clk) begin
    int  sz;
    bit  m_full, m_pop, m_push;
    sz     = mq.size();
    m_full = (sz == DEPTH);
    if (chk_on) begin
      check("m_count", 64'(count), 64'(sz));
      check("m_rn_valid", 64'(rn_valid), 64'(sz != 0));
      check("m_id_ready", 64'(id_ready), 64'(en && !m_full && !flush));
      if (sz != 0) begin
        check("m_rn_pc", 64'(rn_pc), 64'(mq[0][PC_W+DATA_W-1:DATA_W]));
        check("m_rn_data", 64'(rn_data), 64'(mq[0][DATA_W-1:0]));
      end
`ifdef ID_RN_PERF_CNT_EN
      check("m_stall", 64'(stall_cycles), 64'(m_stall));
`endif
    end
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (id_valid && en && m_full && m_stall != 64'hFFFF_FFFF) m_stall++;
      if (en && flush) begin
        mq.delete();
      end else if (en) begin
        m_pop  = (sz != 0) && rn_ready;
        m_push = id_valid && !m_full;
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back({id_pc, id_data});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [PC_W-1:0] pc);
    id_valid = 1'b1;
    id_pc    = pc;
    id_data  = data_of(pc);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; id_valid = 1'b0; rn_ready = 1'b0;
    id_pc = '0; id_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk_on = 1'b1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_rn_valid", 64'(rn_valid), 64'd0);
    check("rst_id_ready", 64'(id_ready), 64'd1);

    // Single push and visibility one cycle later.
    drive_push(32'h100); cyc(); id_valid = 1'b0; #1;
    check("push1_rn_valid", 64'(rn_valid), 64'd1);
    check("push1_rn_pc", 64'(rn_pc), 64'h100);
    check("push1_count", 64'(count), 64'd1);
    rn_ready = 1'b1; cyc(); rn_ready = 1'b0;
    check("pop1_count", 64'(count), 64'd0);

    // Fill to full, offer a bundle that must be dropped, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h100 + 32'(4 * i)); cyc();
    end
    id_valid = 1'b0; #1;
    check("full_count", 64'(count), 64'd4);
    check("full_id_ready", 64'(id_ready), 64'd0);
    drive_push(32'h110); cyc(); id_valid = 1'b0; #1;
    check("drop_count", 64'(count), 64'd4);
    rn_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(rn_pc), 64'(32'h100 + 32'(4 * i)));
      cyc();
    end
    rn_ready = 1'b0; #1;
    check("drain_count", 64'(count), 64'd0);

    // Streaming push+pop across several pointer wraps.
    rn_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(32'h200 + 32'(4 * i)); cyc();
      check("stream_count", 64'(count), 64'd1);
      check("stream_pc", 64'(rn_pc), 64'(32'h200 + 32'(4 * i)));
    end
    id_valid = 1'b0; cyc(); rn_ready = 1'b0; #1;
    check("stream_end_count", 64'(count), 64'd0);

    // Flush wins over simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h280 + 32'(4 * i)); cyc();
    end
    drive_push(32'h300); flush = 1'b1; rn_ready = 1'b1; #1;
    check("flush_id_ready", 64'(id_ready), 64'd0);
    cyc(); flush = 1'b0; id_valid = 1'b0; rn_ready = 1'b0; #1;
    check("flush_count", 64'(count), 64'd0);
    check("flush_rn_valid", 64'(rn_valid), 64'd0);
    drive_push(32'h400); cyc(); id_valid = 1'b0; #1;
    check("post_flush_pc", 64'(rn_pc), 64'h400);
    rn_ready = 1'b1; cyc(); rn_ready = 1'b0;

    // Global enable low freezes the queue.
    drive_push(32'h500); cyc();
    drive_push(32'h504); cyc();
    en = 1'b0; drive_push(32'h508); rn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en0_id_ready", 64'(id_ready), 64'd0);
      cyc();
      check("en0_count", 64'(count), 64'd2);
      check("en0_head", 64'(rn_pc), 64'h500);
    end
    en = 1'b1; id_valid = 1'b0; #1;
    check("en1_head0", 64'(rn_pc), 64'h500);
    cyc();
    check("en1_head1", 64'(rn_pc), 64'h504);
    cyc(); rn_ready = 1'b0;
    check("en1_count", 64'(count), 64'd0);

    // Reset mid-stream empties the queue.
    drive_push(32'h600); cyc();
    drive_push(32'h604); rst = 1'b1; cyc(); rst = 1'b0; id_valid = 1'b0; #1;
    check("midrst_count", 64'(count), 64'd0);

`ifdef ID_RN_PERF_CNT_EN
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h700 + 32'(4 * i)); cyc();
    end
    for (int i = 0; i < 5; i++) cyc();
    id_valid = 1'b0; #1;
    check("perf_stall5", 64'(stall_cycles), 64'd5);
    flush = 1'b1; cyc(); flush = 1'b0; #1;
    check("perf_after_flush", 64'(stall_cycles), 64'd5);
    rst = 1'b1; cyc(); rst = 1'b0; #1;
    check("perf_after_rst", 64'(stall_cycles), 64'd0);
`endif

    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
